ps2_scancode_rx: RTL and testbench

//  PS/2 device-to-host receiver with a scan-code decoder and an event FIFO.

---
 rtl/ps2_scancode_rx_if.sv | 35 +++
 rtl/ps2_scancode_rx.sv | 209 ++++++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_scancode_rx_if.sv
// Event/PS-2 signal bundle for ps2_scancode_rx; slave is the receiver side, master the driver/consumer side.
interface ps2_scancode_rx_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          wait_for_incoming_data;
    logic          start_receiving_data;
    logic          ps2_clk_posedge;
    logic          ps2_clk_negedge;
    logic          ps2_data;
    logic          event_ready;
    logic          event_valid;
    logic [7:0]    event_code;
    logic          event_extended;
    logic          event_break;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          parity_error;
    logic          framing_error;

    modport slave (
        input  wait_for_incoming_data, start_receiving_data, ps2_clk_posedge,
               ps2_clk_negedge, ps2_data, event_ready,
        output event_valid, event_code, event_extended, event_break,
               fifo_count, overflow, parity_error, framing_error
    );

    modport master (
        output wait_for_incoming_data, start_receiving_data, ps2_clk_posedge,
               ps2_clk_negedge, ps2_data, event_ready,
        input  event_valid, event_code, event_extended, event_break,
               fifo_count, overflow, parity_error, framing_error
    );
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 frame receiver, E0/F0 prefix decoder and key-event FIFO.
// Define PS2_PARITY_CHECK_EN to enable odd-parity checking of received bytes.
module ps2_scancode_rx #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input logic              clk,
    input logic              reset,
    ps2_scancode_rx_if.slave bus
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned EW = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state_q;
    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt_q;
    logic          par_q;
    logic [TW-1:0] tmo_q;
    logic          ext_q;
    logic          brk_q;
    logic          byte_ok_q;
    logic [7:0]    byte_q;
    logic          framing_err_q;
    logic          parity_err_q;

    logic          parity_bad_c;
    logic          unused_c;

`ifdef PS2_PARITY_CHECK_EN
    assign parity_bad_c = ~(^{shift_q, par_q});
    assign unused_c     = bus.ps2_clk_negedge;
`else
    assign parity_bad_c = 1'b0;
    assign unused_c     = bus.ps2_clk_negedge ^ par_q;
`endif

    // Frame FSM, timeout watchdog and prefix flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            par_q         <= 1'b0;
            tmo_q         <= '0;
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            byte_ok_q     <= 1'b0;
            byte_q        <= '0;
            framing_err_q <= 1'b0;
            parity_err_q  <= 1'b0;
        end else begin
            framing_err_q <= 1'b0;
            parity_err_q  <= 1'b0;
            byte_ok_q     <= 1'b0;

            if (byte_ok_q) begin
                if (byte_q == 8'hE0) begin
                    ext_q <= 1'b1;
                end else if (byte_q == 8'hF0) begin
                    brk_q <= 1'b1;
                end else begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (bus.wait_for_incoming_data) begin
                        state_q <= S_WAIT;
                    end else if (bus.start_receiving_data) begin
                        state_q   <= S_DATA;
                        bit_cnt_q <= '0;
                        tmo_q     <= '0;
                    end
                end
                S_WAIT: begin
                    if (!bus.wait_for_incoming_data) begin
                        state_q <= S_IDLE;
                    end else if (bus.ps2_clk_posedge && !bus.ps2_data) begin
                        state_q   <= S_DATA;
                        bit_cnt_q <= '0;
                        tmo_q     <= '0;
                    end
                end
                S_DATA, S_PARITY, S_STOP: begin
                    if (bus.ps2_clk_posedge) begin
                        tmo_q <= '0;
                        if (state_q == S_DATA) begin
                            shift_q   <= {bus.ps2_data, shift_q[7:1]};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                state_q <= S_PARITY;
                            end
                        end else if (state_q == S_PARITY) begin
                            par_q   <= bus.ps2_data;
                            state_q <= S_STOP;
                        end else begin
                            state_q       <= S_IDLE;
                            framing_err_q <= ~bus.ps2_data;
                            parity_err_q  <= parity_bad_c;
                            if (!bus.ps2_data || parity_bad_c) begin
                                ext_q <= 1'b0;
                                brk_q <= 1'b0;
                            end else begin
                                byte_ok_q <= 1'b1;
                                byte_q    <= shift_q;
                            end
                        end
                    end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_q       <= S_IDLE;
                        framing_err_q <= 1'b1;
                        ext_q         <= 1'b0;
                        brk_q         <= 1'b0;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [CW-1:0] count_q;
    logic          valid_q;
    logic [EW-1:0] head_q;
    logic          ovf_q;

    logic          push_c;
    logic [EW-1:0] push_data_c;
    logic          pop_c;
    logic          full_c;
    logic          do_push_c;
    logic [PW-1:0] wr_d;
    logic [PW-1:0] rd_d;
    logic [CW-1:0] count_d;
    logic [EW-1:0] head_d;
    logic          ovf_d;

    // FIFO next-state; head is re-registered so it tracks pushes into the read slot
    always_comb begin
        push_c      = byte_ok_q && (byte_q != 8'hE0) && (byte_q != 8'hF0);
        push_data_c = {ext_q, brk_q, byte_q};
        pop_c       = valid_q && bus.event_ready;
        full_c      = (count_q == CW'(FIFO_DEPTH));
        do_push_c   = push_c && (!full_c || pop_c);
        ovf_d       = push_c && full_c && !pop_c;
        wr_d        = do_push_c ? wr_q + PW'(1) : wr_q;
        rd_d        = pop_c ? rd_q + PW'(1) : rd_q;
        count_d     = count_q;
        if (do_push_c && !pop_c) begin
            count_d = count_q + CW'(1);
        end else if (!do_push_c && pop_c) begin
            count_d = count_q - CW'(1);
        end
        head_d = mem_q[rd_d];
        if (count_d == '0) begin
            head_d = '0;
        end else if (do_push_c && (wr_q == rd_d)) begin
            head_d = push_data_c;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (do_push_c) begin
                mem_q[wr_q] <= push_data_c;
            end
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            valid_q <= (count_d != '0);
            head_q  <= head_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.event_valid    = valid_q;
    assign bus.event_extended = head_q[9];
    assign bus.event_break    = head_q[8];
    assign bus.event_code     = head_q[7:0];
    assign bus.fifo_count     = count_q;
    assign bus.overflow       = ovf_q;
    assign bus.parity_error   = parity_err_q;
    assign bus.framing_error  = framing_err_q;
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Self-checking bench for ps2_scancode_rx: directed scenarios plus randomized frames against a queue model.
module tb_ps2_scancode_rx;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 64;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ps2_scancode_rx_if #(.FIFO_DEPTH(DEPTH)) bus ();

    ps2_scancode_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int fails  = 0;
    int ovf_seen = 0, par_seen = 0, frm_seen = 0;
    int m_ovf = 0, m_par = 0, m_frm = 0;
    bit m_ext = 1'b0, m_brk = 1'b0;
    logic [9:0] exp_q [$];

    always @(negedge clk) begin
        if (reset) begin
            if (bus.overflow)      ovf_seen++;
            if (bus.parity_error)  par_seen++;
            if (bus.framing_error) frm_seen++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bit_strobe(input logic b);
        repeat (2) @(posedge clk);
        #1 bus.ps2_data = b;
        bus.ps2_clk_posedge = 1'b1;
        @(posedge clk);
        #1 bus.ps2_clk_posedge = 1'b0;
        bus.ps2_data = 1'b1;
    endtask

    // Returns one step into the cycle after the stop-bit strobe was sampled
    task automatic send_frame(input logic [7:0] d, input bit par_good, input bit stop);
        logic p;
        p = ~^d;
        if (!par_good) p = ~p;
        bit_strobe(1'b0);
        for (int i = 0; i < 8; i++) bit_strobe(d[i]);
        bit_strobe(p);
        bit_strobe(stop);
    endtask

    // Spec-level model: what one received byte does to the prefix flags and event queue
    task automatic model_frame(input logic [7:0] d, input bit par_good, input bit stop);
        bit bad;
        bad = !stop || (PCHK && !par_good);
        if (!stop) m_frm++;
        if (PCHK && !par_good) m_par++;
        if (bad) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (d == 8'hE0) begin
            m_ext = 1'b1;
        end else if (d == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (exp_q.size() < int'(DEPTH)) exp_q.push_back({m_ext, m_brk, d});
            else m_ovf++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic send_key(input logic [7:0] d);
        send_frame(d, 1'b1, 1'b1);
        model_frame(d, 1'b1, 1'b1);
    endtask

    task automatic drain(input string tag);
        logic [9:0] e;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({tag, " count"}, 32'(bus.fifo_count), 32'(exp_q.size()));
        check({tag, " overflows"}, 32'(ovf_seen), 32'(m_ovf));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            check({tag, " valid"}, 32'(bus.event_valid), 32'd1);
            check({tag, " head"}, 32'({bus.event_extended, bus.event_break, bus.event_code}), 32'(e));
            bus.event_ready = 1'b1;
            @(posedge clk);
            #1 bus.event_ready = 1'b0;
        end
        @(negedge clk);
        check({tag, " empty"}, 32'(bus.event_valid), 32'd0);
        check({tag, " count0"}, 32'(bus.fifo_count), 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        int r, n, waited;
        bit seen, stop, pg;

        reset = 1'b0;
        bus.wait_for_incoming_data = 1'b0;
        bus.start_receiving_data   = 1'b0;
        bus.ps2_clk_posedge        = 1'b0;
        bus.ps2_clk_negedge        = 1'b0;
        bus.ps2_data               = 1'b1;
        bus.event_ready            = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset valid", 32'(bus.event_valid), 32'd0);
        check("reset count", 32'(bus.fifo_count), 32'd0);
        check("reset code", 32'(bus.event_code), 32'd0);
        check("reset flags", 32'({bus.event_extended, bus.event_break}), 32'd0);
        check("reset pulses", 32'({bus.overflow, bus.parity_error, bus.framing_error}), 32'd0);
        reset = 1'b1;
        bus.wait_for_incoming_data = 1'b1;

        // single make code, latency N+1 / N+2
        send_frame(8'h1C, 1'b1, 1'b1);
        model_frame(8'h1C, 1'b1, 1'b1);
        @(negedge clk);
        check("1C valid at N+1", 32'(bus.event_valid), 32'd0);
        @(negedge clk);
        check("1C valid at N+2", 32'(bus.event_valid), 32'd1);
        check("1C code", 32'(bus.event_code), 32'h1C);
        check("1C flags", 32'({bus.event_extended, bus.event_break}), 32'd0);
        check("1C count", 32'(bus.fifo_count), 32'd1);
        drain("1C");

        // extended break sequence folds into one event
        send_key(8'hE0);
        send_key(8'hF0);
        send_key(8'h75);
        drain("E0F075");

        // overflow with consumer stalled
        for (int i = 0; i <= int'(DEPTH); i++) send_key(8'h10 + 8'(i));
        repeat (3) @(posedge clk);
        check("overflow single pulse", 32'(ovf_seen), 32'd1);
        drain("overflow");

        // full FIFO with pop coinciding with push
        for (int i = 0; i < int'(DEPTH); i++) send_key(8'h20 + 8'(i));
        send_frame(8'h5A, 1'b1, 1'b1);
        bus.event_ready = 1'b1;
        @(posedge clk);
        #1 bus.event_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back({2'b00, 8'h5A});
        @(negedge clk);
        check("full push+pop count", 32'(bus.fifo_count), 32'(DEPTH));
        drain("full push+pop");

        // stop bit 0 discards byte and clears pending prefix
        send_key(8'hE0);
        send_frame(8'h33, 1'b1, 1'b0);
        model_frame(8'h33, 1'b1, 1'b0);
        @(negedge clk);
        check("stop0 framing at N+1", 32'(bus.framing_error), 32'd1);
        @(negedge clk);
        check("stop0 framing pulse width", 32'(bus.framing_error), 32'd0);
        send_key(8'h2A);
        drain("after stop0");

        // even parity on 0x1C
        send_frame(8'h1C, 1'b0, 1'b1);
        model_frame(8'h1C, 1'b0, 1'b1);
        @(negedge clk);
        check("bad parity pulse", 32'(bus.parity_error), 32'(PCHK));
        drain("bad parity");

        // mid-frame timeout after 4 data bits
        send_key(8'hE0);
        bit_strobe(1'b0);
        for (int i = 0; i < 4; i++) bit_strobe(1'(i & 1));
        seen = 1'b0;
        waited = 0;
        for (int i = 1; i <= int'(TMO) + 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.framing_error) begin
                seen = 1'b1;
                waited = i;
            end
        end
        check("timeout framing seen", 32'(seen), 32'd1);
        check("timeout latency window", 32'(waited >= int'(TMO) && waited <= int'(TMO) + 2), 32'd1);
        m_frm++;
        m_ext = 1'b0;
        m_brk = 1'b0;
        send_key(8'h1C);
        drain("after timeout");

        // randomized frames against the model
        for (int it = 0; it < 12; it++) begin
            n = int'($urandom_range(1, DEPTH + 2));
            for (int k = 0; k < n; k++) begin
                r = int'($urandom_range(0, 99));
                if (r < 20)      d = 8'hE0;
                else if (r < 35) d = 8'hF0;
                else             d = 8'($urandom_range(1, 8'hDF));
                stop = ($urandom_range(0, 9) != 0);
                pg   = ($urandom_range(0, 7) != 0);
                send_frame(d, pg, stop);
                model_frame(d, pg, stop);
            end
            drain("random");
        end

        repeat (3) @(posedge clk);
        check("total parity pulses", 32'(par_seen), 32'(m_par));
        check("total framing pulses", 32'(frm_seen), 32'(m_frm));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
